// File: rtl/control_unit.sv
// Instruction-side control FSM for the RISC-SPM datapath: fetch, decode, execute, memory and branch sequencing.
// Optional macro CU_RESUME_EN adds a `resume` input that leaves S_halt for S_fet1.
`timescale 1ns/1ps
module control_unit #(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int SEL1_SIZE = 3,
    parameter int SEL2_SIZE = 2
) (
    output logic                 load_R0,
    output logic                 load_R1,
    output logic                 load_R2,
    output logic                 load_R3,
    output logic                 load_PC,
    output logic                 inc_PC,
    output logic [SEL1_SIZE-1:0] sel_bus_1,
    output logic [SEL2_SIZE-1:0] sel_bus_2,
    output logic                 load_IR,
    output logic                 load_Add_R,
    output logic                 load_Reg_Y,
    output logic                 load_Reg_Z,
    output logic                 write,
    output logic                 halted,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 zero,
`ifdef CU_RESUME_EN
    input  logic                 resume,
`endif
    input  logic                 clk,
    input  logic                 clr
);

    typedef enum logic [3:0] {
        S_idle = 4'd0,  S_fet1 = 4'd1, S_fet2 = 4'd2, S_dec  = 4'd3,
        S_ex1  = 4'd4,  S_rd1  = 4'd5, S_rd2  = 4'd6, S_wr1  = 4'd7,
        S_wr2  = 4'd8,  S_br1  = 4'd9, S_br2  = 4'd10, S_halt = 4'd11
    } state_t;

    localparam logic [OP_SIZE-1:0] OP_NOP = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_NOT = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_RD  = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_WR  = OP_SIZE'(6);
    localparam logic [OP_SIZE-1:0] OP_BR  = OP_SIZE'(7);
    localparam logic [OP_SIZE-1:0] OP_BRZ = OP_SIZE'(8);

    localparam logic [SEL1_SIZE-1:0] SEL1_PC  = SEL1_SIZE'(4);
    localparam logic [SEL2_SIZE-1:0] SEL2_ALU = SEL2_SIZE'(0);
    localparam logic [SEL2_SIZE-1:0] SEL2_B1  = SEL2_SIZE'(1);
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM = SEL2_SIZE'(2);

    state_t               r_state;
    state_t               w_next_state;
    logic [OP_SIZE-1:0]   w_opcode;
    logic [1:0]           w_src;
    logic [1:0]           w_dest;
    logic [3:0]           w_load_r;
    logic [3:0]           w_dest_onehot;

    assign w_opcode      = instruction[WORD_SIZE-1 -: OP_SIZE];
    assign w_src         = instruction[3:2];
    assign w_dest        = instruction[1:0];
    assign w_dest_onehot = 4'b0001 << w_dest;

    assign load_R0 = w_load_r[0];
    assign load_R1 = w_load_r[1];
    assign load_R2 = w_load_r[2];
    assign load_R3 = w_load_r[3];

    // State register; clr forces S_idle immediately, which also zeroes every strobe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode from current state and instruction fields.
    always_comb begin
        w_next_state = S_halt;
        w_load_r     = 4'b0000;
        load_PC      = 1'b0;
        inc_PC       = 1'b0;
        sel_bus_1    = SEL1_SIZE'(0);
        sel_bus_2    = SEL2_ALU;
        load_IR      = 1'b0;
        load_Add_R   = 1'b0;
        load_Reg_Y   = 1'b0;
        load_Reg_Z   = 1'b0;
        write        = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_idle: w_next_state = S_fet1;
            S_fet1: begin
                sel_bus_1    = SEL1_PC;
                sel_bus_2    = SEL2_B1;
                load_Add_R   = 1'b1;
                w_next_state = S_fet2;
            end
            S_fet2: begin
                sel_bus_2    = SEL2_MEM;
                load_IR      = 1'b1;
                inc_PC       = 1'b1;
                w_next_state = S_dec;
            end
            S_dec: begin
                case (w_opcode)
                    OP_NOP: w_next_state = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1    = SEL1_SIZE'(w_src);
                        sel_bus_2    = SEL2_B1;
                        load_Reg_Y   = 1'b1;
                        w_next_state = S_ex1;
                    end
                    OP_NOT: begin
                        sel_bus_1    = SEL1_SIZE'(w_src);
                        sel_bus_2    = SEL2_ALU;
                        load_Reg_Z   = 1'b1;
                        w_load_r     = w_dest_onehot;
                        w_next_state = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1    = SEL1_PC;
                        sel_bus_2    = SEL2_B1;
                        load_Add_R   = 1'b1;
                        w_next_state = (w_opcode == OP_RD) ? S_rd1 :
                                       (w_opcode == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            sel_bus_1    = SEL1_PC;
                            sel_bus_2    = SEL2_B1;
                            load_Add_R   = 1'b1;
                            w_next_state = S_br1;
                        end else begin
                            // Not taken: step the PC past the branch-target byte.
                            inc_PC       = 1'b1;
                            w_next_state = S_fet1;
                        end
                    end
                    default: w_next_state = S_halt;
                endcase
            end
            S_ex1: begin
                sel_bus_1    = SEL1_SIZE'(w_dest);
                sel_bus_2    = SEL2_ALU;
                load_Reg_Z   = 1'b1;
                w_load_r     = w_dest_onehot;
                w_next_state = S_fet1;
            end
            S_rd1, S_wr1: begin
                sel_bus_2    = SEL2_MEM;
                load_Add_R   = 1'b1;
                inc_PC       = 1'b1;
                w_next_state = (r_state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                sel_bus_2    = SEL2_MEM;
                w_load_r     = w_dest_onehot;
                w_next_state = S_fet1;
            end
            S_wr2: begin
                sel_bus_1    = SEL1_SIZE'(w_src);
                write        = 1'b1;
                w_next_state = S_fet1;
            end
            S_br1: begin
                sel_bus_2    = SEL2_MEM;
                load_Add_R   = 1'b1;
                w_next_state = S_br2;
            end
            S_br2: begin
                sel_bus_2    = SEL2_MEM;
                load_PC      = 1'b1;
                w_next_state = S_fet1;
            end
            S_halt: begin
                halted = 1'b1;
`ifdef CU_RESUME_EN
                if (resume) begin
                    w_next_state = S_fet1;
                end else begin
                    w_next_state = S_halt;
                end
`else
                w_next_state = S_halt;
`endif
            end
            default: w_next_state = S_halt;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle expected strobes plus halt and asynchronous-clear sequences.
`timescale 1ns/1ps
module tb_control_unit;

    logic       clk;
    logic       clr;
    logic [7:0] instruction;
    logic       zero;
    logic       resume;
    logic       load_R0, load_R1, load_R2, load_R3;
    logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write, halted;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic [16:0] act;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [7:0]  instr;
        logic        zero;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [16:0] f1, f2, none, hlt;

    control_unit dut (
        .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
        .load_PC(load_PC), .inc_PC(inc_PC), .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
        .load_IR(load_IR), .load_Add_R(load_Add_R), .load_Reg_Y(load_Reg_Y),
        .load_Reg_Z(load_Reg_Z), .write(write), .halted(halted),
        .instruction(instruction), .zero(zero),
`ifdef CU_RESUME_EN
        .resume(resume),
`endif
        .clk(clk), .clr(clr)
    );

    assign act = {load_R3, load_R2, load_R1, load_R0, load_PC, inc_PC, sel_bus_1, sel_bus_2,
                  load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] e(input logic [3:0] lr, input logic pc, input logic inc,
                                      input logic [2:0] s1, input logic [1:0] s2, input logic ir,
                                      input logic ar, input logic y, input logic z,
                                      input logic w, input logic h);
        return {lr, pc, inc, s1, s2, ir, ar, y, z, w, h};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input string n, input logic [7:0] ins, input logic z, input logic [16:0] ex);
        tbl.push_back('{n, ins, z, ex});
    endtask

    task automatic add_fetch(input logic [7:0] ins);
        add("fet1", ins, 1'b0, f1);
        add("fet2", ins, 1'b1, f2);
    endtask

    // One table row per clock cycle: drive on the falling edge, compare 1 ns later.
    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            instruction = tbl[i].instr;
            zero        = tbl[i].zero;
            #1;
            check(tbl[i].name, tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        f1   = e(4'b0000, 1'b0, 1'b0, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        f2   = e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        none = 17'h00000;
        hlt  = e(4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        clr = 1'b0; instruction = 8'h16; zero = 1'b1; resume = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset", none);
        clr = 1'b1; #1;
        check("idle", none);

        add_fetch(8'h16);
        add("dec_add",  8'h16, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        add("ex1_add",  8'h16, 1'b1, e(4'b0100, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add_fetch(8'h2D);
        add("dec_sub",  8'h2D, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        add("ex1_sub",  8'h2D, 1'b0, e(4'b0010, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add_fetch(8'h49);
        add("dec_not",  8'h49, 1'b0, e(4'b0010, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add_fetch(8'h00);
        add("dec_nop",  8'h00, 1'b1, none);
        add_fetch(8'h53);
        add("dec_rd",   8'h53, 1'b0, f1);
        add("rd1",      8'h53, 1'b0, e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("rd2",      8'h53, 1'b0, e(4'b1000, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(8'h63);
        add("dec_wr",   8'h63, 1'b0, f1);
        add("wr1",      8'h63, 1'b0, e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("wr2_r0",   8'h63, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        add_fetch(8'h80);
        add("dec_brz0", 8'h80, 1'b0, e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(8'h80);
        add("dec_brz1", 8'h80, 1'b1, f1);
        add("br1_z",    8'h80, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("br2_z",    8'h80, 1'b0, e(4'b0000, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(8'h70);
        add("dec_br",   8'h70, 1'b0, f1);
        add("br1",      8'h70, 1'b1, e(4'b0000, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("br2",      8'h70, 1'b1, e(4'b0000, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(8'h3E);
        add("dec_and",  8'h3E, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        add("ex1_and",  8'h3E, 1'b0, e(4'b0100, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add_fetch(8'h67);
        add("dec_wr2",  8'h67, 1'b0, f1);
        add("wr1_b",    8'h67, 1'b0, e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("wr2_r1",   8'h67, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        add_fetch(8'hF0);
        add("dec_ill",  8'hF0, 1'b1, none);
        run_table();

        // Halt must hold regardless of instruction or zero changes.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            instruction = 8'h16 + 8'(i);
            zero        = i[0];
            #1;
            check("halt_hold", hlt);
        end

`ifdef CU_RESUME_EN
        @(negedge clk); resume = 1'b1; #1;
        check("halt_resume_req", hlt);
        @(negedge clk); resume = 1'b0; #1;
        check("resume_fet1", f1);
        @(negedge clk); #1;
        check("resume_fet2", f2);
`endif

        // Asynchronous clear in the middle of a write cycle.
        @(negedge clk); clr = 1'b0; #1;
        check("clr_from_halt", none);
        clr = 1'b1; #1;
        check("idle2", none);
        add_fetch(8'h6B);
        add("dec_wr3",  8'h6B, 1'b0, f1);
        add("wr1_c",    8'h6B, 1'b0, e(4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        add("wr2_r2",   8'h6B, 1'b0, e(4'b0000, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_table();
        #2 clr = 1'b0;
        #1 check("clr_mid_wr2", none);
        @(negedge clk); #1;
        check("clr_held", none);
        clr = 1'b1; #1;
        check("idle3", none);
        add_fetch(8'h00);
        add("dec_nop2", 8'h00, 1'b0, none);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction-side control FSM for the RISC-SPM datapath.
- Reads the opcode and register fields from the instruction register's output and sequences fetch, decode, execute, memory read/write and branch.
- Drives every load, increment, mux-select and memory-write strobe in the processing unit, including load_IR, which writes the instruction register it then reads.

Parameters:
- WORD_SIZE, 8, instruction width. Opcode is [WORD_SIZE-1:WORD_SIZE-4], src is [3:2], dest is [1:0].
- OP_SIZE, 4, opcode field width.
- SEL1_SIZE, 3, Bus_1 mux select width.
- SEL2_SIZE, 2, Bus_2 mux select width.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  async reset, active-low; state goes to S_idle immediately
- instruction  input  WORD_SIZE  instruction register output
- zero  input  1  ALU zero flag from Reg_Z
- load_R0..load_R3  output  1 each  register-file loads
- load_PC  output  1  load PC from Bus_2
- inc_PC  output  1  PC+1
- sel_bus_1  output  SEL1_SIZE  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- sel_bus_2  output  SEL2_SIZE  Bus_2 source: 0=ALU, 1=Bus_1, 2=memory
- load_IR  output  1  instruction register load
- load_Add_R  output  1  address register load
- load_Reg_Y  output  1  ALU operand register load
- load_Reg_Z  output  1  zero-flag register load
- write  output  1  memory write strobe
- halted  output  1  high in S_halt

Behaviour:
- State register uses clk and async clr. All outputs are combinational from the state and the instruction fields; there are no output registers.
- Reset (clr=0): state=S_idle. All strobes are 0, sel_bus_1=0, sel_bus_2=0, halted=0.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Values 9-15 are illegal.
- Any strobe not listed for a state below is 0 in that state.
- S_idle: no outputs -> S_fet1.
- S_fet1: sel_bus_1=PC, sel_bus_2=Bus_1, load_Add_R -> S_fet2.
- S_fet2: sel_bus_2=memory, load_IR, inc_PC -> S_dec.
- S_dec, decoded from instruction:
  - NOP -> S_fet1, no outputs.
  - ADD/SUB/AND: sel_bus_1=src, sel_bus_2=Bus_1, load_Reg_Y -> S_ex1.
  - NOT: sel_bus_1=src, sel_bus_2=ALU, load_Reg_Z, load_R[dest] -> S_fet1.
  - RD/WR/BR: sel_bus_1=PC, sel_bus_2=Bus_1, load_Add_R -> S_rd1 / S_wr1 / S_br1 respectively.
  - BRZ with zero=1: same outputs as BR -> S_br1.
  - BRZ with zero=0: inc_PC only (skips the address byte) -> S_fet1.
  - Illegal opcode -> S_halt, no strobes.
- S_ex1: sel_bus_1=dest, sel_bus_2=ALU, load_Reg_Z, load_R[dest] -> S_fet1.
- S_rd1: sel_bus_2=memory, load_Add_R, inc_PC -> S_rd2.
- S_rd2: sel_bus_2=memory, load_R[dest] -> S_fet1.
- S_wr1: sel_bus_2=memory, load_Add_R, inc_PC -> S_wr2.
- S_wr2: sel_bus_1=src, write -> S_fet1.
- S_br1: sel_bus_2=memory, load_Add_R -> S_br2.
- S_br2: sel_bus_2=memory, load_PC -> S_fet1.
- S_halt: halted=1, no other strobes. Stays in S_halt until clr is asserted.
- At most one load_R* is high in any cycle.
- write and load_IR are never high together.
- Instruction cycle lengths from S_fet1:
  - NOP/NOT: 3 cycles.
  - ADD/SUB/AND: 4 cycles.
  - RD/WR/BR/taken BRZ: 5 cycles.
  - Not-taken BRZ: 3 cycles.
- zero is sampled only in S_dec.
- The instruction input is treated as stable from S_dec onward, since the IR loads only in S_fet2.
- clr asserted in any state, including mid-write in S_wr2: write deasserts combinationally and the state returns to S_idle. No partial completion.
- Undefined state encodings -> S_halt.

Optional Feature:
- Macro: CU_RESUME_EN.
- Defined: adds input port `resume` (1 bit). While in S_halt, resume=1 at a rising clk edge moves the state to S_fet1. The PC is not modified, so execution continues with the byte after the illegal opcode.
- Undefined: no resume port; S_halt is exited only by clr.

Test Plan:
- clr=0 for 2 cycles, then released -> all outputs 0 during reset; S_idle for 1 cycle, then S_fet1 with sel_bus_1=4, sel_bus_2=1, load_Add_R=1.
- instruction=8'h16 (ADD src=R1, dest=R2) -> sequence fet1, fet2, dec, ex1. In dec: sel_bus_1=1, load_Reg_Y=1. In ex1: sel_bus_1=2, sel_bus_2=0, load_R2=1, load_Reg_Z=1. Total 4 cycles.
- instruction=8'h63 (WR src=R0) -> wr1 has inc_PC=1, load_Add_R=1. wr2 has write=1, sel_bus_1=0. Total 5 cycles.
- instruction=8'h80 with zero=0 -> dec asserts inc_PC only, next state S_fet1. Same instruction with zero=1 -> br1, br2 with load_PC=1 in br2.
- instruction=8'hF0 -> halted=1 and held for 20 cycles with all strobes 0. With CU_RESUME_EN defined, resume=1 for one cycle -> next state S_fet1.
- clr pulsed low during S_wr2 -> write drops without waiting for clk, then the S_idle to S_fet1 sequence restarts.
